// File: rtl/liu_gpio_reset_pkg.sv
// Shared types and helpers for the staged GPIO reset sequencer.
//  - seq_state_e : 3-bit sequencer state encoding, also driven out on SEQ_STATE
//  - seq_out_t   : registered output bundle (reset releases plus status flags)
//  - cnt_width   : width of the shared stage counter
//  - decode_outputs : output values that belong to a given state
package liu_gpio_reset_pkg;

  localparam int unsigned StateW = 3;

  typedef enum logic [StateW-1:0] {
    StHold      = 3'd0,
    StWaitLock  = 3'd1,
    StRelFab    = 3'd2,
    StRelPeriph = 3'd3,
    StRelGpio   = 3'd4,
    StRun       = 3'd5,
    StFault     = 3'd6
  } seq_state_e;

  typedef struct packed {
    logic fab_rst_n;
    logic periph_rst_n;
    logic gpio_rst_n;
    logic seq_done;
    logic lock_fault;
  } seq_out_t;

  // One counter serves every timed state, so it is sized for the longest interval.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

  // Release windows nest (GPIO inside peripheral inside fabric), which keeps the
  // ordering GPIO <= PERIPH <= FAB true in every state.
  function automatic seq_out_t decode_outputs(input seq_state_e st);
    seq_out_t o;
    o.fab_rst_n    = st inside {StRelFab, StRelPeriph, StRelGpio, StRun};
    o.periph_rst_n = st inside {StRelPeriph, StRelGpio, StRun};
    o.gpio_rst_n   = st inside {StRelGpio, StRun};
    o.seq_done     = (st == StRun);
    o.lock_fault   = (st == StFault);
    return o;
  endfunction

endpackage

// File: rtl/liu_gpio_reset_seq_if.sv
// Signal bundle between the reset sequencer and its environment.
//  master : drives CCC_LOCK, DEV_RDY, SW_RST_REQ; observes resets and status
//  slave  : the sequencer side (inputs above, drives resets and status)
interface liu_gpio_reset_seq_if;

  logic                                 CCC_LOCK;
  logic                                 DEV_RDY;
  logic                                 SW_RST_REQ;
  logic                                 FAB_RESET_N;
  logic                                 PERIPH_RESET_N;
  logic                                 GPIO_RESET_N;
  logic                                 SEQ_DONE;
  logic                                 LOCK_FAULT;
  logic [liu_gpio_reset_pkg::StateW-1:0] SEQ_STATE;

  modport master (
    output CCC_LOCK, DEV_RDY, SW_RST_REQ,
    input  FAB_RESET_N, PERIPH_RESET_N, GPIO_RESET_N, SEQ_DONE, LOCK_FAULT, SEQ_STATE
  );

  modport slave (
    input  CCC_LOCK, DEV_RDY, SW_RST_REQ,
    output FAB_RESET_N, PERIPH_RESET_N, GPIO_RESET_N, SEQ_DONE, LOCK_FAULT, SEQ_STATE
  );

endinterface

// File: rtl/liu_gpio_sync2.sv
// Two-flop synchronizer for a single asynchronous level.
//  clk_i  : destination clock
//  rst_ni : asynchronous active-low reset, both stages clear to 0
//  d_i    : asynchronous input
//  q_o    : synchronized output, two clk_i edges of latency
module liu_gpio_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/liu_gpio_reset_seq.sv
// Staged reset sequencer on the 50 MHz fabric oscillator clock.
// Holds all fabric resets after power-up, waits for a filtered CCC lock plus
// device-ready, then releases fabric core, peripherals and GPIO in order.
// Lock loss or a software request re-asserts all resets on one edge; a lock
// that never arrives parks the sequencer in FAULT.
//  CLK    : fabric clock
//  RESETN : asynchronous active-low reset
//  bus    : CCC_LOCK / DEV_RDY (async), SW_RST_REQ (1-cycle pulse) in;
//           FAB/PERIPH/GPIO_RESET_N, SEQ_DONE, LOCK_FAULT, SEQ_STATE out
module liu_gpio_reset_seq
  import liu_gpio_reset_pkg::*;
#(
  parameter int unsigned POR_HOLD_CYC     = 1024,
  parameter int unsigned LOCK_FILT_CYC    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYC = 65536,
  parameter int unsigned STAGE_GAP_CYC    = 256
) (
  input logic                 CLK,
  input logic                 RESETN,
  liu_gpio_reset_seq_if.slave bus
);

  localparam int unsigned CntW  = cnt_width(POR_HOLD_CYC, LOCK_TIMEOUT_CYC, STAGE_GAP_CYC);
  localparam int unsigned FiltW = $clog2(LOCK_FILT_CYC) + 1;

  localparam logic [CntW-1:0]  HoldLast    = CntW'(POR_HOLD_CYC - 1);
  localparam logic [CntW-1:0]  TimeoutLast = CntW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CntW-1:0]  GapLast     = CntW'(STAGE_GAP_CYC - 1);
  localparam logic [FiltW-1:0] FiltMax     = FiltW'(LOCK_FILT_CYC);

  logic lock_s;
  logic rdy_s;
  logic lock_ok;

  logic [FiltW-1:0] filt_d, filt_q;
  logic [CntW-1:0]  cnt_d, cnt_q;
  logic             armed_d, armed_q;
  seq_state_e       state_d, state_q;
  seq_out_t         out_d, out_q;

  liu_gpio_sync2 u_sync_lock (
    .clk_i  (CLK),
    .rst_ni (RESETN),
    .d_i    (bus.CCC_LOCK),
    .q_o    (lock_s)
  );

  liu_gpio_sync2 u_sync_rdy (
    .clk_i  (CLK),
    .rst_ni (RESETN),
    .d_i    (bus.DEV_RDY),
    .q_o    (rdy_s)
  );

  // Lock filter runs in every state so a lock that settled during HOLD is
  // already qualified by the time WAIT_LOCK samples it.
  always_comb begin
    filt_d = '0;
    if (lock_s) begin
      filt_d = (filt_q == FiltMax) ? filt_q : filt_q + FiltW'(1);
    end
  end

  assign lock_ok = (filt_q == FiltMax);

  // The first edge after RESETN release only arms the hold counter, so the
  // hold interval is measured from a clean, fully released edge.
  assign armed_d = 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;

    case (state_q)
      StHold: begin
        if (armed_q) begin
          if (cnt_q == HoldLast) state_d = StWaitLock;
          else                   cnt_d   = cnt_q + CntW'(1);
        end
      end
      StWaitLock: begin
        if (lock_ok && rdy_s)         state_d = StRelFab;
        else if (cnt_q == TimeoutLast) state_d = StFault;
        else                           cnt_d   = cnt_q + CntW'(1);
      end
      StRelFab: begin
        if (cnt_q == GapLast) state_d = StRelPeriph;
        else                  cnt_d   = cnt_q + CntW'(1);
      end
      StRelPeriph: begin
        if (cnt_q == GapLast) state_d = StRelGpio;
        else                  cnt_d   = cnt_q + CntW'(1);
      end
      StRelGpio: state_d = StRun;
      StRun:     state_d = StRun;
      StFault:   state_d = StFault;
      default:   state_d = StHold;
    endcase

    // Lock loss is deliberately unfiltered: one low synced sample drops every
    // released domain at once.
    if (!lock_s && (state_q inside {StRelFab, StRelPeriph, StRelGpio, StRun})) begin
      state_d = StHold;
    end

    // Software request wins over everything and restarts the hold interval
    // even when already in HOLD.
    if (bus.SW_RST_REQ) begin
      state_d = StHold;
    end

    if ((state_d != state_q) || bus.SW_RST_REQ) begin
      cnt_d = '0;
    end
  end

  // Outputs are loaded from the next-state decode so they move on the same
  // edge as the state itself.
  always_comb begin
    out_d = decode_outputs(state_d);
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= StHold;
      cnt_q   <= '0;
      filt_q  <= '0;
      armed_q <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      filt_q  <= filt_d;
      armed_q <= armed_d;
      out_q   <= out_d;
    end
  end

  assign bus.FAB_RESET_N    = out_q.fab_rst_n;
  assign bus.PERIPH_RESET_N = out_q.periph_rst_n;
  assign bus.GPIO_RESET_N   = out_q.gpio_rst_n;
  assign bus.SEQ_DONE       = out_q.seq_done;
  assign bus.LOCK_FAULT     = out_q.lock_fault;
  assign bus.SEQ_STATE      = state_q;

endmodule
